dec_fpr_sb_ctl: RTL and testbench
=================================

// Module: dec_fpr_sb_ctl
// PURPOSE
//  Parametrised multi-port register file with integrated scoreboard; successor to the decode GPR block.
//  Provides 3 read ports (FMA-capable) and 2 write ports: port 0 for single-cycle results, port 1 for
//  long-latency FPU results. Per-register busy bits track issued long ops and drive RAW stall / WAW
//  issue-ready. Sits in decode, between the instruction decoder/issue logic and the FPU writeback.
// PARAMETERS
//  XLEN      32  data width of each register
//  NREGS     32  number of architectural registers (power of 2, >=2); AW = $clog2(NREGS) localparam
//  ZERO_REG  1   1: register 0 reads as zero, ignores writes/issues (GPR); 0: register 0 is normal (FPR)
// PORTS
//  clk        in   1       clock
//  rst_l      in   1       asynchronous active-low reset
//  scan_mode  in   1       scan enable, passed to flop cells, no functional effect
//  rden0..2   in   1       read enable per port
//  raddr0..2  in   AW      read address per port
//  rd0..2     out  XLEN    read data per port (combinational)
//  wen0       in   1       single-cycle write enable
//  waddr0     in   AW      write address, port 0
//  wd0        in   XLEN    write data, port 0
//  wen1       in   1       long-latency writeback enable (retires scoreboard entry)
//  waddr1     in   AW      write address, port 1
//  wd1        in   XLEN    write data, port 1
//  iss_valid  in   1       long-latency op issuing, destination iss_waddr
//  iss_waddr  in   AW      destination of issuing op
//  iss_ready  out  1       issue accepted this cycle (no WAW on destination)
//  stall      out  1       RAW hazard: some enabled read port targets a busy register
//  busy_vec   out  NREGS   registered busy bits
//  busy_cnt   out  AW+1    registered count of set busy bits
//  wr_collide out  1       registered 1-cycle pulse: wen0&wen1 same valid address last cycle
// BEHAVIOUR
//  - Reset (rst_l=0, async): all registers=0, busy_vec=0, busy_cnt=0, wr_collide=0; while low rd0..2=0,
//    stall=0, iss_ready=0; writes/issues ignored.
//  - Read: rdN = 0 if !rdenN or (ZERO_REG & raddrN==0); else reg[raddrN]. Zero latency.
//  - Write: on clk rise, wenK writes wdK to reg[waddrK]; writes to reg 0 dropped when ZERO_REG.
//  - Collision wen0&wen1&waddr0==waddr1 (valid addr): port 0 data written, port 1 data dropped,
//    busy clear from port 1 still applied; wr_collide=1 next cycle.
//  - Scoreboard: iss_ready = !busy[iss_waddr] | (wen1 & waddr1==iss_waddr); ZERO_REG & iss_waddr==0 ->
//    iss_ready=1, no busy set. iss_ready independent of iss_valid.
//  - iss_valid&iss_ready sets busy[iss_waddr] next cycle; wen1 clears busy[waddr1] next cycle;
//    same address both -> set wins (busy stays 1). wen1 to non-busy reg: write occurs, busy unchanged.
//  - wen0 never touches busy bits (issue logic must not target a busy reg on port 0).
//  - busy_cnt = popcount(busy_vec), updated same edge as busy_vec; max NREGS (or NREGS-1 if ZERO_REG).
//  - stall = OR over N of (rdenN & busy[raddrN] & !(ZERO_REG & raddrN==0)) (bypass modifies, below).
// CONFIGURATION
//  FPR_BYPASS_EN defined: same-cycle write-to-read forwarding; rdN returns wd0 if wen0&waddr0==raddrN,
//    else wd1 if wen1&waddr1==raddrN, else array; busy read port whose reg is written by wen1 this
//    cycle does not contribute to stall.
//  FPR_BYPASS_EN undefined: reads return pre-write array value; stall asserted while busy bit is set,
//    including the wen1 retire cycle (stall drops the cycle after).
// TESTING
//  1 Reset mid-op: busy_vec=0x0000_0008, drop rst_l -> busy_vec=0, busy_cnt=0, rd0=0 immediately.
//  2 Issue x5 (iss_valid, iss_waddr=5) -> busy_vec[5]=1, busy_cnt=1; rden1,raddr1=5 -> stall=1;
//    wen1,waddr1=5,wd1=0x3F80_0000 -> busy clear next cycle, rd1=0x3F80_0000.
//  3 Busy x7, issue x7 alone -> iss_ready=0; same cycle wen1 waddr1=7 -> iss_ready=1, busy[7] stays 1.
//  4 wen0 waddr0=9 wd0=0xAAAA_AAAA & wen1 waddr1=9 wd1=0x5555_5555 -> reg9=0xAAAA_AAAA, wr_collide=1.
//  5 ZERO_REG=1: wen0 waddr0=0 wd0=0xFFFF_FFFF, rden0 raddr0=0 -> rd0=0; issue x0 -> no busy set.
//  6 FPR_BYPASS_EN: busy x3, wen1 waddr1=3 wd1=0x4000_0000, raddr2=3 -> rd2=0x4000_0000, stall=0;
//    without macro -> rd2=old value, stall=1.

Source files
------------

// File: rtl/dec_fpr_sb_ctl.sv
// Decode register file (3R/2W) with long-latency scoreboard for RAW stall and WAW issue gating.
// Build option: define FPR_BYPASS_EN for same-cycle write-to-read forwarding.
module dec_fpr_sb_ctl #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     scan_mode,
  input  logic                     rden0,
  input  logic                     rden1,
  input  logic                     rden2,
  input  logic [$clog2(NREGS)-1:0] raddr0,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [XLEN-1:0]          rd0,
  output logic [XLEN-1:0]          rd1,
  output logic [XLEN-1:0]          rd2,
  input  logic                     wen0,
  input  logic [$clog2(NREGS)-1:0] waddr0,
  input  logic [XLEN-1:0]          wd0,
  input  logic                     wen1,
  input  logic [$clog2(NREGS)-1:0] waddr1,
  input  logic [XLEN-1:0]          wd1,
  input  logic                     iss_valid,
  input  logic [$clog2(NREGS)-1:0] iss_waddr,
  output logic                     iss_ready,
  output logic                     stall,
  output logic [NREGS-1:0]         busy_vec,
  output logic [$clog2(NREGS):0]   busy_cnt,
  output logic                     wr_collide
);

  localparam int AW = $clog2(NREGS);
  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_cnt;
  logic             r_wr_collide;

  logic [2:0]       w_rden;
  logic [AW-1:0]    w_raddr [3];
  logic [XLEN-1:0]  w_rd [3];
  logic             w_stall;
  logic             w_wr0_ok;
  logic             w_wr1_ok;
  logic             w_collide;
  logic             w_iss_zero;
  logic             w_iss_ready;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_unused;

  function automatic logic [AW:0] popcnt(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + {{AW{1'b0}}, v[i]};
    return c;
  endfunction

  assign w_unused = scan_mode;

  assign w_rden     = {rden2, rden1, rden0};
  assign w_raddr[0] = raddr0;
  assign w_raddr[1] = raddr1;
  assign w_raddr[2] = raddr2;

  // Same-address dual write: port 0 data wins, port 1 still retires its scoreboard entry.
  assign w_wr0_ok  = wen0 && !(ZR && waddr0 == '0);
  assign w_collide = w_wr0_ok && wen1 && (waddr0 == waddr1);
  assign w_wr1_ok  = wen1 && !(ZR && waddr1 == '0) && !w_collide;

  assign w_iss_zero  = ZR && (iss_waddr == '0);
  assign w_iss_ready = rst_l && (w_iss_zero || !r_busy[iss_waddr] ||
                                 (wen1 && waddr1 == iss_waddr));

  always_comb begin
    w_stall = 1'b0;
    for (int p = 0; p < 3; p++) begin
      w_rd[p] = '0;
      if (rst_l && w_rden[p] && !(ZR && w_raddr[p] == '0)) begin
`ifdef FPR_BYPASS_EN
        if (wen0 && waddr0 == w_raddr[p])      w_rd[p] = wd0;
        else if (wen1 && waddr1 == w_raddr[p]) w_rd[p] = wd1;
        else                                   w_rd[p] = r_regs[w_raddr[p]];
        if (r_busy[w_raddr[p]] && !(wen1 && waddr1 == w_raddr[p])) w_stall = 1'b1;
`else
        w_rd[p] = r_regs[w_raddr[p]];
        if (r_busy[w_raddr[p]]) w_stall = 1'b1;
`endif
      end
    end
  end

  // Issue set is applied after the retire clear so a same-address pair leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wen1) w_busy_nxt[waddr1] = 1'b0;
    if (iss_valid && w_iss_ready && !w_iss_zero) w_busy_nxt[iss_waddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy       <= '0;
      r_busy_cnt   <= '0;
      r_wr_collide <= 1'b0;
    end else begin
      if (w_wr0_ok) r_regs[waddr0] <= wd0;
      if (w_wr1_ok) r_regs[waddr1] <= wd1;
      r_busy       <= w_busy_nxt;
      r_busy_cnt   <= popcnt(w_busy_nxt);
      r_wr_collide <= w_collide;
    end
  end

  assign rd0        = w_rd[0];
  assign rd1        = w_rd[1];
  assign rd2        = w_rd[2];
  assign stall      = w_stall;
  assign iss_ready  = w_iss_ready;
  assign busy_vec   = r_busy;
  assign busy_cnt   = r_busy_cnt;
  assign wr_collide = r_wr_collide;

endmodule

// File: tb/tb_dec_fpr_sb_ctl.sv
// Directed table-driven bench for dec_fpr_sb_ctl (XLEN=32, NREGS=32, ZERO_REG=1).
module tb_dec_fpr_sb_ctl;

`ifdef FPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_l;
  logic        scan_mode;
  logic        rden0, rden1, rden2;
  logic [4:0]  raddr0, raddr1, raddr2;
  logic [31:0] rd0, rd1, rd2;
  logic        wen0, wen1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wd0, wd1;
  logic        iss_valid;
  logic [4:0]  iss_waddr;
  logic        iss_ready, stall, wr_collide;
  logic [31:0] busy_vec;
  logic [5:0]  busy_cnt;

  int n_chk = 0;
  int n_err = 0;

  dec_fpr_sb_ctl #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) dut (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode),
    .rden0(rden0), .rden1(rden1), .rden2(rden2),
    .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2),
    .rd0(rd0), .rd1(rd1), .rd2(rd2),
    .wen0(wen0), .waddr0(waddr0), .wd0(wd0),
    .wen1(wen1), .waddr1(waddr1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr), .iss_ready(iss_ready),
    .stall(stall), .busy_vec(busy_vec), .busy_cnt(busy_cnt), .wr_collide(wr_collide)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rden;
    logic [4:0]  ra0, ra1, ra2;
    logic        wen0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        wen1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iv;
    logic [4:0]  ia;
    logic [31:0] e0, e1, e2;
    logic        es, er;
    logic [31:0] eb;
    logic [5:0]  ec;
    logic        ecol;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rden0 = 0; rden1 = 0; rden2 = 0; raddr0 = 0; raddr1 = 0; raddr2 = 0;
    wen0 = 0; waddr0 = 0; wd0 = 0; wen1 = 0; waddr1 = 0; wd1 = 0;
    iss_valid = 0; iss_waddr = 0;
  endtask

  initial begin
    scan_mode = 1'b0;
    rst_l = 1'b0;
    idle();
    //        rden    ra0 ra1 ra2 wen0 wa0 wd0            wen1 wa1 wd1            iv ia  e0 e1 e2 stall rdy  busy cnt col
    vt[0]  = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h1111_1111, 1'b0, 5'd0, 32'h0, 1'b0, 5'd1,
               32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 6'd0, 1'b0};
    vt[1]  = '{3'b011, 5'd3, 5'd9, 5'd0, 1'b1, 5'd9, 32'hAAAA_AAAA, 1'b1, 5'd9, 32'h5555_5555, 1'b0, 5'd0,
               32'h1111_1111, BYP ? 32'hAAAA_AAAA : 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 6'd0, 1'b1};
    vt[2]  = '{3'b010, 5'd0, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
               32'h0, 32'hAAAA_AAAA, 32'h0, 1'b0, 1'b1, 32'h0, 6'd0, 1'b0};
    vt[3]  = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5,
               32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h20, 6'd1, 1'b0};
    vt[4]  = '{3'b010, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5,
               32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 6'd1, 1'b0};
    vt[5]  = '{3'b010, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h3F80_0000, 1'b0, 5'd5,
               32'h0, BYP ? 32'h3F80_0000 : 32'h0, 32'h0, !BYP, 1'b1, 32'h0, 6'd0, 1'b0};
    vt[6]  = '{3'b010, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
               32'h0, 32'h3F80_0000, 32'h0, 1'b0, 1'b1, 32'h0, 6'd0, 1'b0};
    vt[7]  = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
               32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 6'd1, 1'b0};
    vt[8]  = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
               32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h80, 6'd1, 1'b0};
    vt[9]  = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7,
               32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 6'd1, 1'b0};
    vt[10] = '{3'b001, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0,
               32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 6'd1, 1'b0};
    vt[11] = '{3'b101, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3,
               32'h1234_5678, 32'h0, 32'h0, 1'b1, 1'b1, 32'h88, 6'd2, 1'b0};
    vt[12] = '{3'b100, 5'd0, 5'd0, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h4000_0000, 1'b0, 5'd3,
               32'h0, 32'h0, BYP ? 32'h4000_0000 : 32'h1111_1111, !BYP, 1'b1, 32'h80, 6'd1, 1'b0};
    vt[13] = '{3'b110, 5'd0, 5'd7, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0BAD_F00D, 1'b0, 5'd0,
               32'h0, BYP ? 32'h0BAD_F00D : 32'h1234_5678, 32'h4000_0000, !BYP, 1'b1, 32'h0, 6'd0, 1'b0};
    vt[14] = '{3'b001, 5'd10, 5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hCAFE_BABE, 1'b0, 5'd0,
               BYP ? 32'hCAFE_BABE : 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 6'd0, 1'b0};
    vt[15] = '{3'b011, 5'd10, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
               32'hCAFE_BABE, 32'hAAAA_AAAA, 32'h0, 1'b0, 1'b1, 32'h0, 6'd0, 1'b0};
    vt[16] = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2, 1'b0, 5'd0,
               32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 6'd0, 1'b0};

    #1;
    chk("rst_busy_vec", busy_vec, 32'h0);
    chk("rst_busy_cnt", {26'h0, busy_cnt}, 32'h0);
    chk("rst_wr_collide", {31'h0, wr_collide}, 32'h0);
    chk("rst_iss_ready", {31'h0, iss_ready}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst_l = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rden0 = vt[i].rden[0]; rden1 = vt[i].rden[1]; rden2 = vt[i].rden[2];
      raddr0 = vt[i].ra0; raddr1 = vt[i].ra1; raddr2 = vt[i].ra2;
      wen0 = vt[i].wen0; waddr0 = vt[i].wa0; wd0 = vt[i].wd0;
      wen1 = vt[i].wen1; waddr1 = vt[i].wa1; wd1 = vt[i].wd1;
      iss_valid = vt[i].iv; iss_waddr = vt[i].ia;
      #1;
      chk($sformatf("v%0d_rd0", i), rd0, vt[i].e0);
      chk($sformatf("v%0d_rd1", i), rd1, vt[i].e1);
      chk($sformatf("v%0d_rd2", i), rd2, vt[i].e2);
      chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vt[i].es});
      chk($sformatf("v%0d_iss_ready", i), {31'h0, iss_ready}, {31'h0, vt[i].er});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy_vec", i), busy_vec, vt[i].eb);
      chk($sformatf("v%0d_busy_cnt", i), {26'h0, busy_cnt}, {26'h0, vt[i].ec});
      chk($sformatf("v%0d_wr_collide", i), {31'h0, wr_collide}, {31'h0, vt[i].ecol});
    end

    // Asynchronous reset in the middle of an outstanding long op.
    @(negedge clk);
    idle();
    iss_valid = 1'b1; iss_waddr = 5'd3;
    @(posedge clk);
    #1;
    chk("mid_busy_set", busy_vec, 32'h0000_0008);
    @(negedge clk);
    idle();
    rden0 = 1'b1; raddr0 = 5'd9;
    #1;
    chk("mid_rd0_pre", rd0, 32'hAAAA_AAAA);
    #1;
    rst_l = 1'b0;
    #1;
    chk("mid_busy_vec", busy_vec, 32'h0);
    chk("mid_busy_cnt", {26'h0, busy_cnt}, 32'h0);
    chk("mid_rd0", rd0, 32'h0);
    chk("mid_iss_ready", {31'h0, iss_ready}, 32'h0);
    @(negedge clk);
    rst_l = 1'b1;
    #1;
    chk("post_rd0_cleared", rd0, 32'h0);
    chk("post_iss_ready", {31'h0, iss_ready}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
